// File: rtl/system_workers_cpu_3_cpu_mul_seq.sv
// Multi-cycle 32x32 multiply sequencer for the worker CPU execute stage.
// Drives an external registered 16x16 unsigned multiplier cell with operand
// halves, accumulates the returned partial products into a 64-bit
// accumulator, applies signed-operand correction to the high word and
// returns the selected 32-bit word with a one-cycle done pulse.
module system_workers_cpu_3_cpu_mul_seq #(
   parameter int CELL_LAT = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        E_start,
   input  logic [1:0]  E_op,
   input  logic [31:0] E_src1,
   input  logic [31:0] E_src2,
   input  logic        E_flush,
   output logic [15:0] cell_a,
   output logic [15:0] cell_b,
   output logic        cell_en,
   input  logic [31:0] cell_p,
   output logic        M_busy,
   output logic        M_done,
   output logic [31:0] M_result
);

   localparam logic [1:0] OP_MUL    = 2'd0;
   localparam logic [1:0] OP_MULXSS = 2'd2;
   localparam logic [1:0] OP_MULXSU = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_DRAIN = 3'd2,
      ST_FIX   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // FSM state and issue index
   state_t r_state;
   state_t w_state_nxt;
   logic [1:0] r_k;
   logic [1:0] w_k_nxt;

   // captured request
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [1:0]  r_op;

   // accumulator and in-flight tag pipe (bit 0 newest, bit CELL_LAT-1 returning)
   logic [63:0] r_acc;
   logic [CELL_LAT-1:0]      r_vpipe;
   logic [CELL_LAT-1:0]      w_vpipe_nxt;
   logic [CELL_LAT-1:0][1:0] r_spipe;
   logic [CELL_LAT-1:0][1:0] w_spipe_nxt;

   // registered outputs
   logic        r_cell_en;
   logic [15:0] r_cell_a;
   logic [15:0] r_cell_b;
   logic [1:0]  r_cell_k;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_result;

   // combinational helpers
   logic        w_accept;
   logic [1:0]  w_last_k;
   logic        w_older_inflight;
   logic        w_ret_valid;
   logic [1:0]  w_ret_s;
   logic [63:0] w_addend;
   logic        w_cell_en_nxt;
   logic [15:0] w_cell_a_nxt;
   logic [15:0] w_cell_b_nxt;
   logic [31:0] w_src_a;
   logic [31:0] w_src_b;
   logic [31:0] w_corr;
   logic [31:0] w_hi;
   logic [31:0] w_fix_word;

   // Shift amount (in 16-bit units) of a partial product given its issue index.
   function automatic logic [1:0] prod_shift(input logic [1:0] k);
      return {1'b0, k[1]} + {1'b0, k[0]};
   endfunction

   assign cell_en  = r_cell_en;
   assign cell_a   = r_cell_a;
   assign cell_b   = r_cell_b;
   assign M_busy   = r_busy;
   assign M_done   = r_done;
   assign M_result = r_result;

   // Request acceptance, last issue index and returning-product decode.
   always_comb begin
      w_accept    = (r_state == ST_IDLE) && E_start && !E_flush;
      w_last_k    = (r_op == OP_MUL) ? 2'd2 : 2'd3;
      w_ret_valid = r_vpipe[CELL_LAT-1];
      w_ret_s     = r_spipe[CELL_LAT-1];
      w_addend    = {32'd0, cell_p} << {w_ret_s, 4'd0};
      w_older_inflight = 1'b0;
      for (int i = 0; i < CELL_LAT - 1; i++) begin
         w_older_inflight = w_older_inflight | r_vpipe[i];
      end
   end

   // Next-state and issue-index logic; a flush always returns to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      if (E_flush) begin
         w_state_nxt = ST_IDLE;
         w_k_nxt     = 2'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  w_state_nxt = ST_ISSUE;
                  w_k_nxt     = 2'd0;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_ISSUE: begin
               if (r_k == w_last_k) begin
                  w_state_nxt = ST_DRAIN;
                  w_k_nxt     = 2'd0;
               end else begin
                  w_k_nxt     = r_k + 2'd1;
               end
            end
            ST_DRAIN: begin
               // leave once only the returning product (if any) remains in flight
               if (!w_older_inflight) begin
                  w_state_nxt = ST_FIX;
               end else begin
                  w_state_nxt = ST_DRAIN;
               end
            end
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: begin
               w_state_nxt = ST_IDLE;
               w_k_nxt     = 2'd0;
            end
         endcase
      end
   end

   // Operand half selection for the next cycle's issue; halves are 0 when idle.
   always_comb begin
      w_src_a       = (r_state == ST_IDLE) ? E_src1 : r_a;
      w_src_b       = (r_state == ST_IDLE) ? E_src2 : r_b;
      w_cell_en_nxt = (w_state_nxt == ST_ISSUE);
      if (w_cell_en_nxt) begin
         w_cell_a_nxt = w_k_nxt[1] ? w_src_a[31:16] : w_src_a[15:0];
         w_cell_b_nxt = w_k_nxt[0] ? w_src_b[31:16] : w_src_b[15:0];
      end else begin
         w_cell_a_nxt = 16'd0;
         w_cell_b_nxt = 16'd0;
      end
   end

   // Tag pipe advance: newest stage takes this cycle's issue.
   always_comb begin
      w_vpipe_nxt    = r_vpipe;
      w_spipe_nxt    = r_spipe;
      w_vpipe_nxt[0] = r_cell_en;
      w_spipe_nxt[0] = prod_shift(r_cell_k);
      for (int i = 1; i < CELL_LAT; i++) begin
         w_vpipe_nxt[i] = r_vpipe[i-1];
         w_spipe_nxt[i] = r_spipe[i-1];
      end
   end

   // Signed-operand correction of the high word and result word selection.
   always_comb begin
      case (r_op)
         OP_MULXSS: w_corr = (r_a[31] ? r_b : 32'd0) + (r_b[31] ? r_a : 32'd0);
         OP_MULXSU: w_corr = r_a[31] ? r_b : 32'd0;
         default:   w_corr = 32'd0;
      endcase
      w_hi       = r_acc[63:32] - w_corr;
      w_fix_word = (r_op == OP_MUL) ? r_acc[31:0] : w_hi;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_k     <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
      end
   end

   // Request capture, tag pipe and accumulator; flush discards everything in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_op    <= 2'd0;
         r_acc   <= 64'd0;
         r_vpipe <= {CELL_LAT{1'b0}};
         r_spipe <= {(2*CELL_LAT){1'b0}};
      end else begin
         if (w_accept) begin
            r_a  <= E_src1;
            r_b  <= E_src2;
            r_op <= E_op;
         end
         if (E_flush) begin
            r_acc   <= 64'd0;
            r_vpipe <= {CELL_LAT{1'b0}};
            r_spipe <= {(2*CELL_LAT){1'b0}};
         end else begin
            r_vpipe <= w_vpipe_nxt;
            r_spipe <= w_spipe_nxt;
            if (w_accept) begin
               r_acc <= 64'd0;
            end else if (w_ret_valid) begin
               r_acc <= r_acc + w_addend;
            end
         end
      end
   end

   // Registered outputs: cell drive, busy/done flags and the result word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cell_en <= 1'b0;
         r_cell_a  <= 16'd0;
         r_cell_b  <= 16'd0;
         r_cell_k  <= 2'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_result  <= 32'd0;
      end else begin
         r_cell_en <= w_cell_en_nxt;
         r_cell_a  <= w_cell_a_nxt;
         r_cell_b  <= w_cell_b_nxt;
         r_cell_k  <= w_k_nxt;
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_done    <= (w_state_nxt == ST_DONE);
         if ((r_state == ST_FIX) && !E_flush) begin
            r_result <= w_fix_word;
         end
      end
   end

endmodule

// File: tb/tb_system_workers_cpu_3_cpu_mul_seq.sv
// Directed bench for the multiply sequencer with a behavioural multiplier cell.
module tb_system_workers_cpu_3_cpu_mul_seq;

   localparam int LAT = 1;

   logic        clk;
   logic        reset_n;
   logic        E_start;
   logic [1:0]  E_op;
   logic [31:0] E_src1;
   logic [31:0] E_src2;
   logic        E_flush;
   logic [15:0] cell_a;
   logic [15:0] cell_b;
   logic        cell_en;
   logic [31:0] cell_p;
   logic        M_busy;
   logic        M_done;
   logic [31:0] M_result;

   int n_checks = 0;
   int n_err    = 0;

   system_workers_cpu_3_cpu_mul_seq #(.CELL_LAT(LAT)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .E_start  (E_start),
      .E_op     (E_op),
      .E_src1   (E_src1),
      .E_src2   (E_src2),
      .E_flush  (E_flush),
      .cell_a   (cell_a),
      .cell_b   (cell_b),
      .cell_en  (cell_en),
      .cell_p   (cell_p),
      .M_busy   (M_busy),
      .M_done   (M_done),
      .M_result (M_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier cell: LAT-deep product pipe; non-issue slots carry junk.
   logic [31:0] cell_pipe [LAT];
   always @(posedge clk) begin
      cell_pipe[0] <= cell_en ? ({16'd0, cell_a} * {16'd0, cell_b}) : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) cell_pipe[i] <= cell_pipe[i-1];
   end
   assign cell_p = cell_pipe[LAT-1];

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] xa;
      logic [63:0] xb;
      logic [63:0] p;
      xa = (op == 2'd2 || op == 2'd3) ? {{32{a[31]}}, a} : {32'd0, a};
      xb = (op == 2'd2) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = xa * xb;
      return (op == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   // Start strobe sampled at the next rising edge (edge t).
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      E_op = op; E_src1 = a; E_src2 = b; E_start = 1'b1;
      @(posedge clk);
      #1 E_start = 1'b0;
   endtask

   // Observe cycles t+1..t+14; optionally inject a flush or a stray start at a given cycle.
   task automatic watch(input string tag, input int exp_k, input logic [31:0] exp_res,
                        input int exp_iss, input int flush_k, input int start_k);
      int ndone = 0;
      int kdone = 0;
      int niss  = 0;
      int busy_until;
      bit busy_ok = 1'b1;
      bit cell_ok = 1'b1;
      busy_until = (exp_k > 0) ? exp_k : flush_k;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (M_done) begin ndone++; kdone = k; end
         if (cell_en) niss++;
         else if (cell_a != 16'd0 || cell_b != 16'd0) cell_ok = 1'b0;
         if (M_busy !== (k <= busy_until)) busy_ok = 1'b0;
         E_flush = (k == flush_k);
         E_start = (k == start_k);
      end
      E_flush = 1'b0; E_start = 1'b0;
      chk({tag, ".ndone"}, 64'(ndone), (exp_k > 0) ? 64'd1 : 64'd0);
      chk({tag, ".done_cycle"}, 64'(kdone), 64'(exp_k));
      chk({tag, ".issues"}, 64'(niss), 64'(exp_iss));
      chk({tag, ".busy"}, 64'(busy_ok), 64'd1);
      chk({tag, ".cell_zero"}, 64'(cell_ok), 64'd1);
      chk({tag, ".result"}, {32'd0, M_result}, {32'd0, exp_res});
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      int nd;
      reset_n = 1'b0; E_start = 1'b0; E_op = 2'd0; E_src1 = 32'd0; E_src2 = 32'd0; E_flush = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.flags", {61'd0, M_busy, M_done, cell_en}, 64'd0);
      chk("reset.data", {M_result, cell_a, cell_b}, 64'd0);
      reset_n = 1'b1;

      issue(2'd0, 32'h0001_0003, 32'h0002_0005);
      watch("mul", 6, 32'h000B_000F, 3, 0, 0);
      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      watch("mulxuu", 7, 32'hFFFF_FFFE, 4, 0, 0);
      issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      watch("mulxss", 7, 32'h0000_0000, 4, 0, 0);
      issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      watch("mulxsu", 7, 32'hFFFF_FFFF, 4, 0, 0);
      issue(2'd2, 32'h8000_0000, 32'h7FFF_FFFF);
      watch("mulxss_min", 7, 32'hC000_0000, 4, 0, 0);

      // flush at t+3: result holds, then a clean MUL is unaffected by stale products
      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      watch("flush", 0, 32'hC000_0000, 3, 3, 0);
      issue(2'd0, 32'd7, 32'd6);
      watch("after_flush", 6, 32'h0000_002A, 3, 0, 0);

      // start and flush together in IDLE: request dropped
      @(negedge clk);
      E_op = 2'd0; E_src1 = 32'd9; E_src2 = 32'd9; E_start = 1'b1; E_flush = 1'b1;
      @(posedge clk);
      #1 begin E_start = 1'b0; E_flush = 1'b0; end
      watch("start_flush", 0, 32'h0000_002A, 0, 0, 0);

      // stray start at t+2 while busy is ignored
      issue(2'd0, 32'd3, 32'd5);
      watch("busy_start", 6, 32'd15, 3, 0, 2);

      // start held through DONE: ignored there, accepted in the following IDLE cycle
      issue(2'd0, 32'h10, 32'h10);
      E_op = 2'd1; E_src1 = 32'hFFFF_FFFF; E_src2 = 32'd2; E_start = 1'b1;
      nd = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (M_done) nd++;
      end
      chk("hold.done_at6", {63'd0, M_done}, 64'd1);
      chk("hold.result", {32'd0, M_result}, 64'h100);
      chk("hold.ndone", 64'(nd), 64'd1);
      @(negedge clk);
      chk("hold.idle_after_done", {63'd0, M_busy}, 64'd0);
      @(posedge clk);
      #1 E_start = 1'b0;
      watch("reissue", 7, 32'd1, 4, 0, 0);

      // asynchronous reset mid-operation
      issue(2'd0, 32'd11, 32'd13);
      @(negedge clk);
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("async_reset.flags", {61'd0, M_busy, M_done, cell_en}, 64'd0);
      chk("async_reset.data", {M_result, cell_a, cell_b}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      nd = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (M_done || M_busy) nd++;
      end
      chk("async_reset.quiet", 64'(nd), 64'd0);

      // random operands, including sign-boundary picks
      for (int n = 0; n < 200; n++) begin
         rop = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 4))
            0:       ra = 32'h8000_0000;
            1:       ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0:       rb = 32'h7FFF_FFFF;
            1:       rb = 32'h8000_0001;
            default: rb = $urandom;
         endcase
         issue(rop, ra, rb);
         watch("rand", (rop == 2'd0) ? 6 : 7, ref_mul(rop, ra, rb), (rop == 2'd0) ? 3 : 4, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
